// File: rtl/elastic_fifo_buffer.sv
// Multi-entry valid/ready elastic buffer with occupancy count, almost-full flag and a
// synchronous flush. Handshake outputs depend only on registered state and flush.
module elastic_fifo_buffer #(
    parameter type T           = logic [31:0],
    parameter int  DEPTH       = 4,
    parameter int  AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid_in,
    input  T                           data_in,
    output logic                       ready_in,
    input  logic                       ready_out,
    output logic                       valid_out,
    output T                           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign ready_in    = !flush && (count != FULL_CNT);
    assign valid_out   = !flush && (count != '0);
    assign data_out    = mem[rd_ptr];
    assign almost_full = (count >= AFULL_CNT);
    assign push        = valid_in && ready_in;
    assign pop         = valid_out && ready_out;

    // Explicit pointer wrap so DEPTH need not be a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
